// File: rtl/mycpu_pkg.sv
// Shared CPU definitions: reset vector, instruction width/NOP and the
// prefetch queue entry layout used by if_prefetch and if_inst_fifo.
package mycpu_pkg;

  localparam logic [31:0]  RESET_PC_DEFAULT = 32'h1c00_0000;
  localparam int unsigned  INST_W           = 32;
  localparam logic [INST_W-1:0] NOP_INST    = 32'h0340_0000;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/if_inst_fifo.sv
// Synchronous prefetch queue: one write port, one read port, flush,
// wrapping pointers and a separate 0..DEPTH occupancy counter.
module if_inst_fifo
  import mycpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      flush_i,
  input  logic      wr_en_i,
  input  fq_entry_t wr_data_i,
  input  logic      rd_en_i,
  output fq_entry_t rd_data_o,
  output logic [4:0] count_o,
  output logic      empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fq_entry_t       mem_q [DEPTH];
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [4:0]      cnt_q;
  logic            full, wr, rd;

  assign full      = (cnt_q == 5'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign wr        = wr_en_i && !full && !flush_i;
  assign rd        = rd_en_i && !empty_o && !flush_i;
  assign count_o   = cnt_q;
  assign rd_data_o = mem_q[rptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr) wptr_q <= wptr_q + PW'(1);
      if (rd) rptr_q <= rptr_q + PW'(1);
      case ({wr, rd})
        2'b10:   cnt_q <= cnt_q + 5'd1;
        2'b01:   cnt_q <= cnt_q - 5'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr) mem_q[wptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/if_prefetch.sv
// Instruction fetch with prefetch queue and branch redirect/flush.
// Optional same-cycle bypass of empty queue: define IF_PREFETCH_BYPASS_EN.
module if_prefetch
  import mycpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned QDEPTH   = 4
) (
  input  logic              clk,
  input  logic              resetn,
  output logic              inst_sram_we,
  output logic [31:0]       inst_sram_addr,
  output logic [31:0]       inst_sram_wdata,
  input  logic [INST_W-1:0] inst_sram_rdata,
  input  logic              br_taken,
  input  logic [31:0]       br_target,
  input  logic              ds_allow_in,
  output logic              fs_to_ds_valid,
  output logic [31:0]       fs_to_ds_pc,
  output logic [INST_W-1:0] fs_to_ds_inst,
  output logic [4:0]        fs_qcnt
);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic        inflight_q, inflight_d;
  logic [4:0]  qcnt;
  logic        q_empty, issue, resp_vld, push, pop;
  fq_entry_t   head, resp;

  assign inst_sram_we    = 1'b0;
  assign inst_sram_wdata = '0;
  assign inst_sram_addr  = {fetch_pc_q[31:2], 2'b00};
  assign fs_qcnt         = qcnt;

  assign issue    = !br_taken && (({1'b0, qcnt} + {5'b0, inflight_q}) < 6'(QDEPTH));
  assign resp_vld = inflight_q && !br_taken;
  assign resp     = '{pc: inflight_pc_q, inst: inst_sram_rdata};
  assign pop      = !q_empty && !br_taken && ds_allow_in;

`ifdef IF_PREFETCH_BYPASS_EN
  // An empty queue hands the arriving response straight to decode; it is
  // only enqueued if decode does not take it this cycle.
  assign push = resp_vld && !(q_empty && ds_allow_in);
  always_comb begin
    fs_to_ds_valid = 1'b0;
    fs_to_ds_pc    = '0;
    fs_to_ds_inst  = '0;
    if (!q_empty) begin
      fs_to_ds_valid = !br_taken;
      fs_to_ds_pc    = head.pc;
      fs_to_ds_inst  = head.inst;
    end else if (resp_vld) begin
      fs_to_ds_valid = 1'b1;
      fs_to_ds_pc    = resp.pc;
      fs_to_ds_inst  = resp.inst;
    end
  end
`else
  assign push           = resp_vld;
  assign fs_to_ds_valid = !q_empty && !br_taken;
  assign fs_to_ds_pc    = q_empty ? '0 : head.pc;
  assign fs_to_ds_inst  = q_empty ? '0 : head.inst;
`endif

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = issue;
    if (br_taken) begin
      fetch_pc_d = {br_target[31:2], 2'b00};
    end else if (issue) begin
      fetch_pc_d    = fetch_pc_q + 32'd4;
      inflight_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
    end
  end

  if_inst_fifo #(
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_ni    (resetn),
    .flush_i   (br_taken),
    .wr_en_i   (push),
    .wr_data_i (resp),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .count_o   (qcnt),
    .empty_o   (q_empty)
  );

endmodule
